// File: rtl/inv_sbox_engine.sv
// Multi-cycle AES InvSubBytes engine: latches a masked byte matrix and substitutes
// BYTES_PER_CYCLE bytes per clock through the FIPS-197 inverse S-box.
module inv_sbox_engine #(
   parameter int NO_ROWS         = 4,
   parameter int NO_COLS         = 4,
   parameter int BYTES_PER_CYCLE = 4
) (
   input  logic                                 clk,
   input  logic                                 resetn,
   input  logic                                 inv_sbox_ip_valid,
   output logic                                 inv_sbox_ip_ready,
   input  logic [NO_ROWS-1:0][NO_COLS-1:0][7:0] inv_sbox_ip_char_matrix,
   input  logic [NO_ROWS-1:0]                   inv_sbox_ip_char_row_mask,
   input  logic [NO_COLS-1:0]                   inv_sbox_ip_char_col_mask,
   output logic                                 inv_sbox_op_char_matrix_valid,
   input  logic                                 inv_sbox_op_ready,
   output logic [NO_ROWS-1:0][NO_COLS-1:0][7:0] inv_sbox_op_char_matrix,
   output logic                                 inv_sbox_busy
);

   localparam int TOTAL = NO_ROWS * NO_COLS;
   localparam int CNT_W = $clog2(TOTAL) + 1;
   localparam logic [CNT_W-1:0] TOTAL_C = CNT_W'(TOTAL);
   localparam logic [CNT_W-1:0] STEP_C  = CNT_W'(BYTES_PER_CYCLE);

   if ((BYTES_PER_CYCLE < 1) || (TOTAL % BYTES_PER_CYCLE != 0)) begin : g_bad_step
      $error("BYTES_PER_CYCLE must divide NO_ROWS*NO_COLS");
   end

   localparam logic [7:0] INV_SBOX [256] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

   state_e                               state_q, state_d;
   logic [CNT_W-1:0]                     cnt_q, cnt_d;
   logic [NO_ROWS-1:0][NO_COLS-1:0][7:0] mat_q, mat_d;
   logic [NO_ROWS-1:0]                   row_mask_q, row_mask_d;
   logic [NO_COLS-1:0]                   col_mask_q, col_mask_d;
   logic [NO_ROWS-1:0][NO_COLS-1:0][7:0] out_q, out_d;

   function automatic logic [7:0] inv_sub(input logic [7:0] b);
      return INV_SBOX[b];
   endfunction

   // True when linear byte index k falls in this cycle's slice [base, base+STEP).
   function automatic logic in_window(input logic [CNT_W-1:0] k, input logic [CNT_W-1:0] base);
      return (k >= base) && ((k - base) < STEP_C);
   endfunction

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (inv_sbox_ip_valid) state_d = BUSY;
         BUSY:    if (cnt_d == TOTAL_C) state_d = DONE;
         DONE:    if (inv_sbox_op_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      inv_sbox_ip_ready             = (state_q == IDLE);
      inv_sbox_op_char_matrix_valid = (state_q == DONE);
      inv_sbox_busy                 = (state_q != IDLE);
   end

   always_comb begin
      cnt_d      = cnt_q;
      mat_d      = mat_q;
      row_mask_d = row_mask_q;
      col_mask_d = col_mask_q;
      out_d      = out_q;
      case (state_q)
         IDLE: begin
            if (inv_sbox_ip_valid) begin
               mat_d      = inv_sbox_ip_char_matrix;
               row_mask_d = inv_sbox_ip_char_row_mask;
               col_mask_d = inv_sbox_ip_char_col_mask;
               cnt_d      = '0;
               out_d      = '0;
            end
         end
         BUSY: begin
            cnt_d = cnt_q + STEP_C;
            for (int i = 0; i < NO_ROWS; i++) begin
               for (int j = 0; j < NO_COLS; j++) begin
                  if (in_window(CNT_W'(i * NO_COLS + j), cnt_q)) begin
                     out_d[i][j] = (row_mask_q[i] && col_mask_q[j]) ? inv_sub(mat_q[i][j]) : 8'h00;
                  end
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_q      <= '0;
         mat_q      <= '0;
         row_mask_q <= '0;
         col_mask_q <= '0;
         out_q      <= '0;
      end else begin
         cnt_q      <= cnt_d;
         mat_q      <= mat_d;
         row_mask_q <= row_mask_d;
         col_mask_q <= col_mask_d;
         out_q      <= out_d;
      end
   end

   assign inv_sbox_op_char_matrix = out_q;

endmodule

// File: doc/inv_sbox_engine.md
Name: inv_sbox_engine

Overview:
- Multi-cycle AES InvSubBytes unit for the decryption core; the inverse of the encryption-side S-box substitution.
- Accepts a NO_ROWS x NO_COLS byte matrix with row and column masks over a valid/ready handshake.
- Substitutes BYTES_PER_CYCLE bytes per clock through an internal 256-entry inverse S-box table (FIPS-197 InvSbox).
- Presents the result matrix under a valid/ready output handshake.

Parameters:
- NO_ROWS, 4, rows in the state matrix.
- NO_COLS, 4, columns in the state matrix.
- BYTES_PER_CYCLE, 4, bytes substituted per BUSY cycle. Must divide NO_ROWS*NO_COLS; otherwise elaboration fails.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- resetn  input  1  asynchronous active-low reset.
- inv_sbox_ip_valid  input  1  input matrix and masks valid.
- inv_sbox_ip_ready  output  1  engine can accept a matrix.
- inv_sbox_ip_char_matrix  input  8 x [NO_ROWS][NO_COLS]  ciphertext-side state bytes.
- inv_sbox_ip_char_row_mask  input  NO_ROWS  rows selected for substitution.
- inv_sbox_ip_char_col_mask  input  NO_COLS  columns selected for substitution.
- inv_sbox_op_char_matrix_valid  output  1  result matrix valid.
- inv_sbox_op_ready  input  1  downstream accepts the result.
- inv_sbox_op_char_matrix  output  8 x [NO_ROWS][NO_COLS]  substituted matrix.
- inv_sbox_busy  output  1  high in BUSY and DONE.

Behaviour:
- Reset values (resetn low, asynchronous):
  - state = IDLE; byte counter = 0.
  - inv_sbox_ip_ready = 1 (it is combinationally state==IDLE).
  - inv_sbox_op_char_matrix_valid = 0; inv_sbox_busy = 0.
  - All inv_sbox_op_char_matrix bytes = 8'h00; internal input and mask latches cleared.
- Byte ordering: linear index k = i*NO_COLS + j, row-major. TOTAL = NO_ROWS*NO_COLS. Counter width is clog2(TOTAL)+1.
- State machine:
  - IDLE:
    - inv_sbox_ip_ready=1.
    - On a clock edge with inv_sbox_ip_valid=1, latch the matrix and both masks, clear the counter, and go to BUSY.
    - On the same edge, clear the output matrix to 8'h00.
  - BUSY:
    - Each cycle, for k = counter .. counter+BYTES_PER_CYCLE-1, write output[i][j] = InvSbox[latched[i][j]] if row_mask[i] && col_mask[j], else 8'h00.
    - Counter += BYTES_PER_CYCLE.
    - When the updated counter reaches TOTAL, go to DONE.
  - DONE:
    - inv_sbox_op_char_matrix_valid=1 and the output matrix is held stable.
    - On an edge with inv_sbox_op_ready=1, go to IDLE; valid drops in the same edge.
- InvSbox index: the high nibble selects the table row and the low nibble the column, as in the forward table. The table is a constant ROM with no reset dependency.
- Latency:
  - Valid rises TOTAL/BYTES_PER_CYCLE cycles after the accept edge (4 cycles with defaults).
  - Minimum initiation interval is TOTAL/BYTES_PER_CYCLE + 2 cycles: the DONE handshake cycle, then the IDLE accept cycle.
- Input isolation:
  - inv_sbox_ip_valid is ignored outside IDLE.
  - Changes to the input ports after the accept edge have no effect on the result.
- Output hold: while DONE with inv_sbox_op_ready=0, the output is held indefinitely with no change.
- inv_sbox_op_ready outside DONE has no effect.
- Simultaneous events: only one transaction is in flight. Acceptance of a new matrix is never combined with the output handshake in the same cycle.
- Mask edge cases:
  - All-zero masks give an all-zero result after the full latency; no early completion.
  - Masks are sampled only at the accept edge.
- Reset mid-operation (BUSY or DONE): immediate return to reset values. The partial result is discarded and the output is never flagged valid.

Test Plan:
- Single-byte check, defaults, all masks 1:
  - Input all 8'h63 except [0][0]=8'h00, [3][3]=8'h16 -> valid 4 cycles after accept.
  - Output: [0][0]=8'h52, [3][3]=8'hff, all others 8'h00.
- Round-trip: drive every one of the 256 byte values in 16 matrices.
  - Feed the forward S-box outputs (e.g. 8'hed, 8'h7c) and require the original indices back (8'h53, 8'h01).
- Masking: row_mask=4'b0101, col_mask=4'b0011, all inputs 8'h63.
  - Output: [0][0],[0][1],[2][0],[2][1] = 8'h00, all other bytes = 8'h00.
  - Then repeat with inputs 8'h7c: only those four bytes = 8'h01, the rest 8'h00.
- Backpressure: hold inv_sbox_op_ready=0 for 10 cycles after valid.
  - Output and valid stay stable.
  - ip_ready stays 0 and a pulsed ip_valid with new data is ignored.
  - After ready=1, the next accepted matrix produces its own result.
- Reset mid-BUSY: assert resetn=0 two cycles after accept.
  - All outputs 0 asynchronously, ip_ready=1 after release, valid never asserted for the aborted matrix.
- Parameter sweep: BYTES_PER_CYCLE=1 and 16 with defaults otherwise.
  - Valid latency 16 and 1 cycles respectively, with identical results to the first test.
